// File: rtl/fsk_pkg.sv
// Shared types and constants for the FSK phase sequencer.
// Imported by the sequencer top level.
package fsk_pkg;

   localparam int unsigned PHASE_W_DEF = 32;

   // First preamble bit; later preamble bits alternate from it.
   localparam logic PREAMBLE_START = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_DATA
   } state_e;

endpackage

// File: rtl/fsk_symbol_timer.sv
// Bit-period counter for the FSK sequencer.
// wrap_o marks the last cycle of each bit period.
module fsk_symbol_timer #(
   parameter int unsigned SYMBOL_CYCLES = 1250
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic hold_i,
   output logic wrap_o
);

   localparam int unsigned CW = $clog2(SYMBOL_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(SYMBOL_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Count 0..LAST and wrap; held at zero while idle.
   always_comb begin
      cnt_d  = cnt_q;
      wrap_o = 1'b0;
      if (hold_i) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         cnt_d  = '0;
         wrap_o = 1'b1;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/fsk_phase_sequencer.sv
// FSK control stage: preamble, LSB-first data, mark/space
// phase increments for the NCO, with a one-byte holding register.
module fsk_phase_sequencer
   import fsk_pkg::*;
#(
   parameter int unsigned PHASE_W       = PHASE_W_DEF,
   parameter int unsigned SYMBOL_CYCLES = 1250,
   parameter int unsigned PREAMBLE_BITS = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [7:0]         in_data,
   input  logic               in_valid,
   input  logic               in_last,
   output logic               in_ready,
   input  logic [PHASE_W-1:0] mark_inc,
   input  logic [PHASE_W-1:0] space_inc,
   output logic [PHASE_W-1:0] phi_inc_o,
   output logic               tx_en,
   output logic               sym_strobe,
   output logic               underrun
);

   localparam int unsigned PW =
      (PREAMBLE_BITS > 1) ? $clog2(PREAMBLE_BITS) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PREAMBLE_BITS - 1);

   state_e               state_q, state_d;
   logic                 hold_valid_q, hold_valid_d;
   logic [7:0]           hold_data_q, hold_data_d;
   logic                 hold_last_q, hold_last_d;
   logic [7:0]           shift_q, shift_d;
   logic                 byte_last_q, byte_last_d;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic [PW-1:0]        pre_cnt_q, pre_cnt_d;
   logic [PW-1:0]        pre_nxt;
   logic [PHASE_W-1:0]   mark_q, mark_d;
   logic [PHASE_W-1:0]   space_q, space_d;
   logic [PHASE_W-1:0]   phi_q, phi_d;
   logic                 tx_en_q, tx_en_d;
   logic                 strobe_q, strobe_d;
   logic                 underrun_q, underrun_d;
   logic                 wrap;

   function automatic logic [PHASE_W-1:0] pick(
      input logic               b,
      input logic [PHASE_W-1:0] m,
      input logic [PHASE_W-1:0] s
   );
      return b ? m : s;
   endfunction

   fsk_symbol_timer #(
      .SYMBOL_CYCLES (SYMBOL_CYCLES)
   ) u_timer (
      .clk_i  (clk),
      .rst_ni (reset_n),
      .hold_i (state_q == ST_IDLE),
      .wrap_o (wrap)
   );

   assign in_ready   = ~hold_valid_q;
   assign phi_inc_o  = phi_q;
   assign tx_en      = tx_en_q;
   assign sym_strobe = strobe_q;
   assign underrun   = underrun_q;
   assign pre_nxt    = pre_cnt_q + PW'(1);

   // Next-state, holding register and registered NCO outputs.
   always_comb begin
      state_d      = state_q;
      hold_valid_d = hold_valid_q;
      hold_data_d  = hold_data_q;
      hold_last_d  = hold_last_q;
      shift_d      = shift_q;
      byte_last_d  = byte_last_q;
      bit_cnt_d    = bit_cnt_q;
      pre_cnt_d    = pre_cnt_q;
      mark_d       = mark_q;
      space_d      = space_q;
      phi_d        = phi_q;
      tx_en_d      = tx_en_q;
      strobe_d     = 1'b0;
      underrun_d   = 1'b0;

      if (in_valid && !hold_valid_q) begin
         hold_valid_d = 1'b1;
         hold_data_d  = in_data;
         hold_last_d  = in_last;
      end

      unique case (state_q)
         ST_IDLE: begin
            phi_d   = '0;
            tx_en_d = 1'b0;
            if (hold_valid_q) begin
               mark_d    = mark_inc;
               space_d   = space_inc;
               pre_cnt_d = '0;
               phi_d     = pick(PREAMBLE_START, mark_inc, space_inc);
               tx_en_d   = 1'b1;
               strobe_d  = 1'b1;
               state_d   = ST_PREAMBLE;
            end
         end
         ST_PREAMBLE: begin
            if (wrap) begin
               strobe_d = 1'b1;
               if (pre_cnt_q == PRE_LAST) begin
                  shift_d      = hold_data_q;
                  byte_last_d  = hold_last_q;
                  hold_valid_d = 1'b0;
                  bit_cnt_d    = '0;
                  phi_d        = pick(hold_data_q[0], mark_q, space_q);
                  state_d      = ST_DATA;
               end else begin
                  pre_cnt_d = pre_nxt;
                  phi_d     = pick(PREAMBLE_START ^ pre_nxt[0],
                                   mark_q, space_q);
               end
            end
         end
         ST_DATA: begin
            if (wrap) begin
               if (bit_cnt_q != 3'd7) begin
                  shift_d   = shift_q >> 1;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  phi_d     = pick(shift_q[1], mark_q, space_q);
                  strobe_d  = 1'b1;
               end else if (!byte_last_q && hold_valid_q) begin
                  shift_d      = hold_data_q;
                  byte_last_d  = hold_last_q;
                  hold_valid_d = 1'b0;
                  bit_cnt_d    = '0;
                  phi_d        = pick(hold_data_q[0], mark_q, space_q);
                  strobe_d     = 1'b1;
               end else begin
                  underrun_d = ~byte_last_q;
                  phi_d      = '0;
                  tx_en_d    = 1'b0;
                  state_d    = ST_IDLE;
               end
            end
         end
         default: begin
            phi_d   = '0;
            tx_en_d = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         hold_valid_q <= 1'b0;
         hold_data_q  <= '0;
         hold_last_q  <= 1'b0;
         shift_q      <= '0;
         byte_last_q  <= 1'b0;
         bit_cnt_q    <= '0;
         pre_cnt_q    <= '0;
         mark_q       <= '0;
         space_q      <= '0;
         phi_q        <= '0;
         tx_en_q      <= 1'b0;
         strobe_q     <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_valid_q <= hold_valid_d;
         hold_data_q  <= hold_data_d;
         hold_last_q  <= hold_last_d;
         shift_q      <= shift_d;
         byte_last_q  <= byte_last_d;
         bit_cnt_q    <= bit_cnt_d;
         pre_cnt_q    <= pre_cnt_d;
         mark_q       <= mark_d;
         space_q      <= space_d;
         phi_q        <= phi_d;
         tx_en_q      <= tx_en_d;
         strobe_q     <= strobe_d;
         underrun_q   <= underrun_d;
      end
   end

endmodule

// File: tb/tb_fsk_phase_sequencer.sv
// Self-checking bench for fsk_phase_sequencer.
// Expected per-bit increments are queued and popped on sym_strobe.
module tb_fsk_phase_sequencer;

   localparam int SC = 4;
   localparam int PB = 4;
   localparam logic [31:0] EXP_M = 32'h100;
   localparam logic [31:0] EXP_S = 32'h080;
   localparam int FRAME1 = (PB + 8) * SC;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic [31:0] mark_inc = EXP_M;
   logic [31:0] space_inc = EXP_S;
   logic [31:0] phi_inc_o;
   logic        tx_en;
   logic        sym_strobe;
   logic        underrun;

   int errors = 0;
   int checks = 0;

   logic [31:0] sb[$];
   bit  mon_en = 1'b0;
   bit  prev_tx = 1'b0;
   int  run_len = 0;
   int  gap_len = 0;
   int  last_len = 0;
   int  last_gap = 0;
   int  frames_done = 0;
   int  underrun_cnt = 0;
   int  phi_idle_bad = 0;
   bit  last_end_underrun = 1'b0;

   fsk_phase_sequencer #(
      .PHASE_W       (32),
      .SYMBOL_CYCLES (SC),
      .PREAMBLE_BITS (PB)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .mark_inc   (mark_inc),
      .space_inc  (space_inc),
      .phi_inc_o  (phi_inc_o),
      .tx_en      (tx_en),
      .sym_strobe (sym_strobe),
      .underrun   (underrun)
   );

   always #5 clk = ~clk;

   // Monitor: scoreboard pops on strobe, frame/gap bookkeeping.
   always @(negedge clk) begin
      if (mon_en && sym_strobe) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL strobe_unexpected phi=%h", phi_inc_o);
         end else begin
            logic [31:0] e;
            e = sb.pop_front();
            if (phi_inc_o !== e) begin
               errors++;
               $display("FAIL bit_inc got=%h exp=%h", phi_inc_o, e);
            end
         end
      end
      if (underrun === 1'b1) underrun_cnt++;
      if (tx_en === 1'b1) begin
         if (!prev_tx) begin
            last_gap = gap_len;
            gap_len = 0;
         end
         run_len++;
      end else begin
         if (phi_inc_o !== 32'h0) phi_idle_bad++;
         if (prev_tx) begin
            last_len = run_len;
            run_len = 0;
            frames_done++;
            last_end_underrun = underrun;
         end
         gap_len++;
      end
      prev_tx = (tx_en === 1'b1);
   end

   task automatic push_preamble();
      for (int i = 0; i < PB; i++)
         sb.push_back((i % 2 == 0) ? EXP_M : EXP_S);
   endtask

   task automatic push_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++)
         sb.push_back(b[i] ? EXP_M : EXP_S);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic last);
      int t;
      t = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (t >= 1000) begin
         errors++;
         $display("FAIL send_timeout in_ready=%b exp=1", in_ready);
      end
      in_data  = d;
      in_last  = last;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_ready_rise();
      int t;
      t = 0;
      while (in_ready !== 1'b0 && t < 50) begin
         @(negedge clk);
         t++;
      end
      while (in_ready !== 1'b1 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (t >= 1000) begin
         errors++;
         $display("FAIL ready_timeout in_ready=%b exp=1", in_ready);
      end
   endtask

   task automatic wait_frame_end();
      int t;
      int start;
      t = 0;
      start = frames_done;
      while (frames_done == start && t < 2000) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (t >= 2000) begin
         errors++;
         $display("FAIL frame_timeout frames=%0d exp>%0d",
                  frames_done, start);
      end
   endtask

   task automatic check_sb_empty(input string nm);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_bits_left got=%0d exp=0", nm, sb.size());
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checks += 5;
      if (phi_inc_o !== 32'h0) begin
         errors++;
         $display("FAIL rst_phi got=%h exp=0", phi_inc_o);
      end
      if (tx_en !== 1'b0) begin
         errors++;
         $display("FAIL rst_tx_en got=%b exp=0", tx_en);
      end
      if (sym_strobe !== 1'b0) begin
         errors++;
         $display("FAIL rst_strobe got=%b exp=0", sym_strobe);
      end
      if (underrun !== 1'b0) begin
         errors++;
         $display("FAIL rst_underrun got=%b exp=0", underrun);
      end
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_in_ready got=%b exp=1", in_ready);
      end
      mon_en = 1'b1;
   endtask

   task automatic test_single_byte();
      int u0;
      u0 = underrun_cnt;
      push_preamble();
      push_byte(8'hA5);
      send_byte(8'hA5, 1'b1);
      wait_frame_end();
      check_sb_empty("single");
      checks += 2;
      if (last_len != FRAME1) begin
         errors++;
         $display("FAIL single_len got=%0d exp=%0d", last_len, FRAME1);
      end
      if (underrun_cnt != u0) begin
         errors++;
         $display("FAIL single_underrun got=%0d exp=%0d",
                  underrun_cnt, u0);
      end
   endtask

   task automatic test_gapless();
      int u0;
      u0 = underrun_cnt;
      push_preamble();
      push_byte(8'h00);
      push_byte(8'hFF);
      send_byte(8'h00, 1'b0);
      wait_ready_rise();
      repeat (20) @(negedge clk);
      send_byte(8'hFF, 1'b1);
      wait_frame_end();
      check_sb_empty("gapless");
      checks += 2;
      if (last_len != (PB + 16) * SC) begin
         errors++;
         $display("FAIL gapless_len got=%0d exp=%0d",
                  last_len, (PB + 16) * SC);
      end
      if (underrun_cnt != u0) begin
         errors++;
         $display("FAIL gapless_underrun got=%0d exp=%0d",
                  underrun_cnt, u0);
      end
   endtask

   task automatic test_underrun();
      int u0;
      u0 = underrun_cnt;
      push_preamble();
      push_byte(8'h3C);
      send_byte(8'h3C, 1'b0);
      wait_frame_end();
      check_sb_empty("underrun");
      checks += 3;
      if (last_len != FRAME1) begin
         errors++;
         $display("FAIL underrun_len got=%0d exp=%0d", last_len, FRAME1);
      end
      if (underrun_cnt != u0 + 1) begin
         errors++;
         $display("FAIL underrun_pulses got=%0d exp=%0d",
                  underrun_cnt - u0, 1);
      end
      if (last_end_underrun !== 1'b1) begin
         errors++;
         $display("FAIL underrun_at_fall got=%b exp=1",
                  last_end_underrun);
      end
      repeat (5) @(negedge clk);
      push_preamble();
      push_byte(8'h5A);
      send_byte(8'h5A, 1'b1);
      wait_frame_end();
      check_sb_empty("restart");
      checks++;
      if (last_len != FRAME1) begin
         errors++;
         $display("FAIL restart_len got=%0d exp=%0d", last_len, FRAME1);
      end
   endtask

   task automatic test_mark_change();
      push_preamble();
      push_byte(8'h96);
      send_byte(8'h96, 1'b1);
      repeat (6) @(negedge clk);
      mark_inc  = 32'h777;
      space_inc = 32'h333;
      wait_frame_end();
      mark_inc  = EXP_M;
      space_inc = EXP_S;
      check_sb_empty("mark_chg");
   endtask

   task automatic test_back_to_back();
      push_preamble();
      push_byte(8'hC3);
      push_preamble();
      push_byte(8'h81);
      send_byte(8'hC3, 1'b1);
      wait_ready_rise();
      send_byte(8'h81, 1'b1);
      wait_frame_end();
      wait_frame_end();
      check_sb_empty("b2b");
      checks += 2;
      if (last_gap != 1) begin
         errors++;
         $display("FAIL b2b_idle_cycles got=%0d exp=1", last_gap);
      end
      if (last_len != FRAME1) begin
         errors++;
         $display("FAIL b2b_len got=%0d exp=%0d", last_len, FRAME1);
      end
   endtask

   task automatic test_reset_mid_frame();
      int hi;
      mon_en = 1'b0;
      send_byte(8'h0F, 1'b0);
      wait_ready_rise();
      send_byte(8'hF0, 1'b1);
      repeat (3) @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_held in_ready got=%b exp=0", in_ready);
      end
      reset_n = 1'b0;
      #1;
      checks += 5;
      if (phi_inc_o !== 32'h0) begin
         errors++;
         $display("FAIL mid_rst_phi got=%h exp=0", phi_inc_o);
      end
      if (tx_en !== 1'b0) begin
         errors++;
         $display("FAIL mid_rst_tx_en got=%b exp=0", tx_en);
      end
      if (sym_strobe !== 1'b0) begin
         errors++;
         $display("FAIL mid_rst_strobe got=%b exp=0", sym_strobe);
      end
      if (underrun !== 1'b0) begin
         errors++;
         $display("FAIL mid_rst_underrun got=%b exp=0", underrun);
      end
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_rst_in_ready got=%b exp=1", in_ready);
      end
      @(negedge clk);
      reset_n = 1'b1;
      hi = 0;
      repeat (30) begin
         @(negedge clk);
         if (tx_en === 1'b1) hi++;
      end
      checks++;
      if (hi != 0) begin
         errors++;
         $display("FAIL mid_discard tx_cycles got=%0d exp=0", hi);
      end
      sb.delete();
      mon_en = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_gapless();
      test_underrun();
      test_mark_change();
      test_back_to_back();
      test_reset_mid_frame();
      checks++;
      if (phi_idle_bad != 0) begin
         errors++;
         $display("FAIL idle_phi_nonzero got=%0d exp=0", phi_idle_bad);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fsk_phase_sequencer.md
# fsk_phase_sequencer

Byte-stream FSK modulator control stage directly upstream of the NCO on the DAC path. Accepts framed bytes over a valid/ready handshake, prepends an alternating preamble, serialises data LSB-first and drives the NCO phase-increment input with the mark or space increment for each bit period. A `tx_en` output lets the top level mute the DAC (drive mid-scale) between frames.

## Interface
- `PHASE_W`, 32: width of the phase increments; matches the NCO `phi_inc_i`.
- `SYMBOL_CYCLES`, 1250: clocks per bit (100 kbaud at 125 MHz); must be at least 2.
- `PREAMBLE_BITS`, 16: alternating bits sent before data, starting with 1; must be at least 1.
- `clk` in 1: sample clock (the 125 MHz PLL output).
- `reset_n` in 1: asynchronous, active-low reset.
- `in_data` in 8: payload byte.
- `in_valid` in 1: `in_data` and `in_last` are valid.
- `in_last` in 1: this byte ends the frame.
- `in_ready` out 1: the holding register is empty.
- `mark_inc` in PHASE_W: phase increment for bit 1.
- `space_inc` in PHASE_W: phase increment for bit 0.
- `phi_inc_o` out PHASE_W: registered increment to the NCO.
- `tx_en` out 1: high while a frame is on air.
- `sym_strobe` out 1: one-cycle pulse on the first cycle of every bit.
- `underrun` out 1: one-cycle pulse when a frame aborts for lack of data.

## Operation
- Reset values: `phi_inc_o`=0, `tx_en`=0, `sym_strobe`=0, `underrun`=0. State is IDLE, the holding register is empty and `in_ready`=1.
- Holding register (one byte plus its last flag):
  - Loads on `in_valid && in_ready`.
  - `in_ready` = not `hold_valid`. There is no bypass: a byte cannot be accepted in the same cycle the holding register drains.
- States:
  - IDLE: `phi_inc_o`=0 and `tx_en`=0. When `hold_valid`=1, sample `mark_inc`/`space_inc` into internal registers and go to PREAMBLE.
  - PREAMBLE: send `PREAMBLE_BITS` bits as 1,0,1,0,… On the last cycle of the last preamble bit, move the holding register into the shift register, clear `hold_valid` and go to DATA.
  - DATA: send 8 bits, LSB first. At the end of bit 7:
    - If the current byte is marked last, go to IDLE.
    - Else if `hold_valid`=1, reload the shift register from the holding register and stay in DATA.
    - Else pulse `underrun` and go to IDLE.
- While `tx_en`=1, `phi_inc_o` = sampled `mark_inc` when the current bit is 1, else sampled `space_inc`. Changes on `mark_inc`/`space_inc` during a frame are ignored.
- Symbol counter:
  - Counts 0..SYMBOL_CYCLES-1 and wraps to 0.
  - Held at 0 in IDLE.
  - Bit boundaries occur only at the wrap.
- Asserting `reset_n` low mid-frame clears the state immediately, including any held byte, and all outputs return to their reset values. A partial frame is never resumed.
- `in_last` on the byte that starts a frame gives a frame of preamble plus one byte.

## Timing
- Frame start:
  - `hold_valid` rises at edge k.
  - At edge k+1: IDLE→PREAMBLE, `tx_en`=1, `phi_inc_o`=mark_inc, `sym_strobe`=1.
- Each new bit value appears on `phi_inc_o` in the same cycle that `sym_strobe` is high.
- Frame length = (PREAMBLE_BITS + 8·N)·SYMBOL_CYCLES cycles of `tx_en`=1 for N bytes. `tx_en` falls at the wrap that ends the final bit; `phi_inc_o` becomes 0 in the same cycle.
- `in_ready` rises one cycle after each shift-register load.
- For gapless frames, the next byte must be accepted within 8·SYMBOL_CYCLES−1 cycles of that rise.
- `underrun` is high in the first IDLE cycle, simultaneous with `tx_en` falling.
- A back-to-back frame is supported: if a new byte is held when the frame ends, IDLE lasts exactly one cycle before the next PREAMBLE.

## Structure
- Package `fsk_pkg`:
  - State enum (IDLE, PREAMBLE, DATA).
  - Default `PHASE_W`.
  - Preamble start-bit constant (1).
- Sub-module `fsk_symbol_timer`: the symbol counter, the wrap/strobe output, and a hold-at-zero input driven from IDLE.

## Test plan
- SYMBOL_CYCLES=4, PREAMBLE_BITS=4, mark=0x100, space=0x080, one byte 0xA5 with last -> `phi_inc_o` per bit: 100,080,100,080 then 100,080,100,080,080,100,080,100; `tx_en` high for exactly 48 cycles.
- Two bytes 0x00, 0xFF, second byte supplied 20 cycles after `in_ready` rises -> continuous 16 data bits, no gap, no `underrun`.
- Two-byte frame whose second byte is withheld -> `underrun` pulses once after the 8th data bit, `tx_en` falls in that same cycle, and a later byte starts a fresh preamble.
- `mark_inc` changed mid-frame -> output keeps the value sampled at frame start until the frame ends.
- `reset_n` pulsed low during DATA while a byte is held -> all outputs 0 immediately, `in_ready`=1, held byte discarded.
- Next frame's byte held at the end of a frame -> exactly one IDLE cycle with `phi_inc_o`=0, then the preamble restarts with mark.
